// File: rtl/alu_result_demux8.sv
// alu_result_demux8: registered 1-to-8 distributor for ALU result words.
// One input word per cycle is steered to a single lane (or to all eight
// lanes in broadcast mode). Each lane owns a one-entry holding register
// with its own valid/ready handshake, so a stalled consumer only blocks
// writes aimed at its own lane.
module alu_result_demux8 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic             bcast,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [15:0]      acc_cnt
);

  logic [7:0]       full_q;
  logic [7:0]       full_d;
  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [15:0]      acc_cnt_q;
  logic [15:0]      acc_cnt_d;

  logic [7:0]       laneFree;
  logic [7:0]       loadMask;
  logic             transfer;

  // A lane can take a new word when it is empty or being drained this cycle;
  // broadcast needs every lane free so that no partial write can happen.
  always_comb begin
    laneFree = ~full_q | out_ready;
    in_ready = bcast ? (&laneFree) : laneFree[sel];
    transfer = in_valid & in_ready;
    loadMask = 8'h00;
    if (transfer) begin
      loadMask = bcast ? 8'hFF : (8'h01 << sel);
    end
  end

  // Next-state for each lane: a load wins over a drain, so a lane that is
  // drained and reloaded in the same cycle stays full with the new word.
  always_comb begin
    full_d    = full_q;
    acc_cnt_d = acc_cnt_q + {15'd0, transfer};
    for (int i = 0; i < 8; i++) begin
      data_d[i] = data_q[i];
      if (loadMask[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = din;
      end else if (out_ready[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  // State registers; reset discards any held words and any same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 8'h00;
      acc_cnt_q <= 16'd0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      full_q    <= full_d;
      acc_cnt_q <= acc_cnt_d;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = full_q;
  assign acc_cnt   = acc_cnt_q;
  assign a = data_q[0];
  assign b = data_q[1];
  assign c = data_q[2];
  assign d = data_q[3];
  assign e = data_q[4];
  assign f = data_q[5];
  assign g = data_q[6];
  assign h = data_q[7];

endmodule
